// File: rtl/gift_pkg.sv
// rtl/gift_pkg.sv - shared state enum, inverse S-box table, constant positions and inverse bit permutation for GIFT-64
package gift_pkg;

  localparam int RC_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARK  = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Inverse of the GIFT nibble S-box, indexed by the substituted nibble
  localparam logic [3:0] INV_SBOX [16] = '{
    4'hD, 4'h0, 4'h8, 4'h6, 4'h2, 4'hC, 4'h4, 4'hB,
    4'hE, 4'h7, 4'h1, 4'hA, 4'h3, 4'h9, 4'hF, 4'h5
  };

  // Round-constant bit c_j lands on state bit RC_POS[j]
  localparam int RC_POS [6] = '{3, 7, 11, 15, 19, 23};

  // Fixed '1' injected with every round key
  localparam int ONE_BIT_POS = 63;

  // Undo PermBits: the encryption round moved bit P(i) from bit i, so pull it back
  function automatic logic [63:0] inv_perm64(input logic [63:0] s);
    logic [63:0] r;
    int          p;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      p    = 4 * (i / 16) + 16 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
      r[i] = s[p];
    end
    return r;
  endfunction

endpackage

// File: rtl/gift_inv_sbox.sv
// rtl/gift_inv_sbox.sv - combinational 8-bit inverse S-box built from two nibble lookups
module gift_inv_sbox
  import gift_pkg::*;
(
  input  logic [7:0] i_din,
  output logic [7:0] o_dout
);

  assign o_dout = {INV_SBOX[i_din[7:4]], INV_SBOX[i_din[3:0]]};

endmodule

// File: rtl/gift64_inv_round.sv
// rtl/gift64_inv_round.sv - iterative GIFT-64 inverse round; define GIFT_INV_PARALLEL_SBOX_EN for single-cycle SUB
module gift64_inv_round
  import gift_pkg::*;
#(
  parameter int RC_W  = RC_W_DEF,
  parameter int BYTES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     state_in,
  input  logic [31:0]     rk_in,
  input  logic [RC_W-1:0] rc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     state_out
);

  state_t            r_state;
  state_t            w_next;
  logic [63:0]       r_s;
  logic [31:0]       r_rk;
  logic [RC_W-1:0]   r_rc;
  logic [63:0]       r_state_out;
  logic [63:0]       w_ark_x;
  logic [63:0]       w_ark;
  logic [63:0]       w_sub;
  logic              w_last;

  // Round key, round constants and the fixed top bit, then undo the permutation
  always_comb begin
    w_ark_x = r_s;
    for (int i = 0; i < 16; i++) begin
      w_ark_x[4*i+1] = w_ark_x[4*i+1] ^ r_rk[16+i];
      w_ark_x[4*i]   = w_ark_x[4*i]   ^ r_rk[i];
    end
    for (int j = 0; j < RC_W; j++) begin
      w_ark_x[RC_POS[j]] = w_ark_x[RC_POS[j]] ^ r_rc[j];
    end
    w_ark_x[ONE_BIT_POS] = ~w_ark_x[ONE_BIT_POS];
  end

  assign w_ark = inv_perm64(w_ark_x);

`ifdef GIFT_INV_PARALLEL_SBOX_EN
  for (genvar g = 0; g < BYTES; g++) begin : g_sbox
    gift_inv_sbox u_sbox (
      .i_din  (r_s[8*g +: 8]),
      .o_dout (w_sub[8*g +: 8])
    );
  end

  assign w_last = 1'b1;
`else
  logic [2:0] r_cnt;
  logic [7:0] w_sb_in;
  logic [7:0] w_sb_out;

  assign w_sb_in = r_s[{r_cnt, 3'b000} +: 8];

  gift_inv_sbox u_sbox (
    .i_din  (w_sb_in),
    .o_dout (w_sb_out)
  );

  // Splice the freshly substituted byte back into the working state
  always_comb begin
    w_sub                        = r_s;
    w_sub[{r_cnt, 3'b000} +: 8] = w_sb_out;
  end

  assign w_last = (r_cnt == 3'(BYTES - 1));

  // Byte pointer: cleared in ARK, steps through bytes during SUB, wraps on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
    end else if (r_state == ST_ARK) begin
      r_cnt <= 3'd0;
    end else if (r_state == ST_SUB) begin
      r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_ARK;
      ST_ARK:  w_next = ST_SUB;
      ST_SUB:  if (w_last) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // Working state and result register; the result only moves when SUB completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_rk        <= '0;
      r_rc        <= '0;
      r_state_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_s  <= state_in;
            r_rk <= rk_in;
            r_rc <= rc_in;
          end
        end
        ST_ARK: r_s <= w_ark;
        ST_SUB: begin
          r_s <= w_sub;
          if (w_last) r_state_out <= w_sub;
        end
        default: ;
      endcase
    end
  end

  assign state_out = r_state_out;

endmodule
